// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and helpers for the register bank
package reg_file_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_ADDR = 0;
  function automatic int addr_width(int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
  function automatic logic [7:0] lane_merge(logic [7:0] old_b, logic [7:0] new_b, logic strb);
    return strb ? new_b : old_b;
  endfunction
endpackage

// File: rtl/reg_file_word.sv
// reg_file_word: one byte-strobed register with a sticky written flag
module reg_file_word
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic [WIDTH-1:0]   q,
  output logic               written
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q <= '0;
      written <= 1'b0;
    end else if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) q[8*i+:8] <= lane_merge(q[8*i+:8], wdata[8*i+:8], wstrb[i]);
      if (|wstrb) written <= 1'b1;
    end
endmodule

// File: rtl/reg_file_bank.sv
// reg_file_bank: two async read ports, one byte-strobed write port, optional bypass and zero register
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = addr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]  raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  output logic               rvalid_a,
  input  logic [ADDR_W-1:0]  raddr_b,
  output logic [WIDTH-1:0]   rdata_b,
  output logic               rvalid_b
);
  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] flags;
  logic             wr_ok;
  assign wr_ok = we && reset && (32'(waddr) < DEPTH) && !(ZERO_REG && waddr == ADDR_W'(ZERO_ADDR));
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (ZERO_REG && g == ZERO_ADDR) begin : g_zero
      assign words[g] = '0;
      assign flags[g] = 1'b0;
    end else begin : g_reg
      reg_file_word #(.WIDTH(WIDTH)) u_word (
        .clk(clk),
        .reset(reset),
        .we(we && waddr == ADDR_W'(g)),
        .wdata(wdata),
        .wstrb(wstrb),
        .q(words[g]),
        .written(flags[g])
      );
    end
  end
  // Both read ports are identical; out-of-range addresses read as empty
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  stored, merged, rd;
    logic              hit, zero, byp, rv;
    assign a      = (p == 0) ? raddr_a : raddr_b;
    assign hit    = 32'(a) < DEPTH;
    assign zero   = ZERO_REG && a == ADDR_W'(ZERO_ADDR);
    assign byp    = BYPASS && wr_ok && a == waddr;
    assign stored = hit ? words[a] : '0;
    always_comb begin
      merged = '0;
      for (int i = 0; i < WIDTH / 8; i++) merged[8*i+:8] = lane_merge(stored[8*i+:8], wdata[8*i+:8], wstrb[i]);
    end
    assign rd = byp ? merged : stored;
    assign rv = zero || (byp && |wstrb) || (hit && flags[a]);
  end
  assign rdata_a  = g_port[0].rd;
  assign rvalid_a = g_port[0].rv;
  assign rdata_b  = g_port[1].rd;
  assign rvalid_b = g_port[1].rv;
endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed and randomized checks of three bank configurations against an array model
module tb_reg_file_bank;
  logic        clk = 1'b0, reset = 1'b0, we = 1'b0;
  logic [4:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rda [3], rdb [3];
  logic        rva [3], rvb [3];
  int          n_checks = 0, n_fail = 0;
  logic [31:0] mem [3][32];
  logic        flg [3][32];
  int          depth [3] = '{32, 32, 20};
  bit          byp [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_file_bank #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(rda[0]), .rvalid_a(rva[0]),
    .raddr_b(raddr_b), .rdata_b(rdb[0]), .rvalid_b(rvb[0]));
  reg_file_bank #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(rda[1]), .rvalid_a(rva[1]),
    .raddr_b(raddr_b), .rdata_b(rdb[1]), .rvalid_b(rvb[1]));
  reg_file_bank #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_d20 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(rda[2]), .rvalid_a(rva[2]),
    .raddr_b(raddr_b), .rdata_b(rdb[2]), .rvalid_b(rvb[2]));

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i+:8] = n[8*i+:8];
    return o;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < 3; k++) for (int i = 0; i < 32; i++) begin
        mem[k][i] <= '0;
        flg[k][i] <= 1'b0;
      end
    end else if (we && waddr != 0 && wstrb != 0) begin
      for (int k = 0; k < 3; k++) if (int'(waddr) < depth[k]) begin
        mem[k][waddr] <= merge(mem[k][waddr], wdata, wstrb);
        flg[k][waddr] <= 1'b1;
      end
    end

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (a == 0 || int'(a) >= depth[k]) return '0;
    if (byp[k] && reset && we && waddr == a) return merge(mem[k][a], wdata, wstrb);
    return mem[k][a];
  endfunction

  function automatic logic exp_rv(int k, logic [4:0] a);
    if (a == 0) return 1'b1;
    if (int'(a) >= depth[k]) return 1'b0;
    if (byp[k] && reset && we && waddr == a && wstrb != 0) return 1'b1;
    return flg[k][a];
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge clk);
    #1 we = 1'b0; wstrb = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #100;
    raddr_a = 5'd5; raddr_b = 5'd31;
    #1;
    n_checks += 4;
    if (rda[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a got %h exp 00000000", rda[0]); end
    if (rdb[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_b got %h exp 00000000", rdb[0]); end
    if (rva[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_a got %b exp 0", rva[0]); end
    if (rvb[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_b got %b exp 0", rvb[0]); end
    raddr_a = 5'd0;
    #1;
    n_checks += 2;
    if (rva[0] !== 1'b1) begin n_fail++; $display("FAIL reset_zero_rvalid got %b exp 1", rva[0]); end
    if (rda[0] !== 32'h0) begin n_fail++; $display("FAIL reset_zero_rdata got %h exp 00000000", rda[0]); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_full_write;
    wr(5'd7, 32'hDEADBEEF, 4'hF);
    raddr_a = 5'd7; raddr_b = 5'd7;
    #1;
    n_checks += 4;
    if (rda[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_rdata_a got %h exp deadbeef", rda[0]); end
    if (rdb[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_rdata_b got %h exp deadbeef", rdb[0]); end
    if (rva[0] !== 1'b1) begin n_fail++; $display("FAIL full_rvalid_a got %b exp 1", rva[0]); end
    if (rvb[0] !== 1'b1) begin n_fail++; $display("FAIL full_rvalid_b got %b exp 1", rvb[0]); end
  endtask

  task automatic test_strobe;
    wr(5'd7, 32'h11223344, 4'b0101);
    raddr_a = 5'd7;
    #1;
    n_checks++;
    if (rda[0] !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_rdata got %h exp de22be44", rda[0]); end
  endtask

  task automatic test_zero_range;
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    raddr_a = 5'd0;
    #1;
    n_checks += 2;
    if (rda[0] !== 32'h0) begin n_fail++; $display("FAIL zero_rdata got %h exp 00000000", rda[0]); end
    if (rva[0] !== 1'b1) begin n_fail++; $display("FAIL zero_rvalid got %b exp 1", rva[0]); end
    wr(5'd25, 32'hCAFEF00D, 4'hF);
    raddr_a = 5'd25;
    #1;
    n_checks += 3;
    if (rda[2] !== 32'h0) begin n_fail++; $display("FAIL range_rdata got %h exp 00000000", rda[2]); end
    if (rva[2] !== 1'b0) begin n_fail++; $display("FAIL range_rvalid got %b exp 0", rva[2]); end
    if (rda[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL depth32_addr25 got %h exp cafef00d", rda[0]); end
  endtask

  task automatic test_bypass;
    wr(5'd3, 32'hAAAAAAAA, 4'hF);
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; wstrb = 4'b0011; raddr_a = 5'd3;
    #1;
    n_checks += 2;
    if (rda[0] !== 32'hAAAA5678) begin n_fail++; $display("FAIL bypass_on got %h exp aaaa5678", rda[0]); end
    if (rda[1] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL bypass_off_before got %h exp aaaaaaaa", rda[1]); end
    @(posedge clk);
    #1 we = 1'b0; wstrb = '0;
    #1;
    n_checks++;
    if (rda[1] !== 32'hAAAA5678) begin n_fail++; $display("FAIL bypass_off_after got %h exp aaaa5678", rda[1]); end
  endtask

  task automatic test_async_reset;
    wr(5'd9, 32'h00000055, 4'b0001);
    raddr_a = 5'd9;
    #1;
    n_checks++;
    if (rda[0] !== 32'h55) begin n_fail++; $display("FAIL async_pre got %h exp 00000055", rda[0]); end
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h77; wstrb = 4'hF;
    #2 reset = 1'b0;
    #1;
    n_checks += 2;
    if (rda[0] !== 32'h0) begin n_fail++; $display("FAIL async_rdata got %h exp 00000000", rda[0]); end
    if (rva[0] !== 1'b0) begin n_fail++; $display("FAIL async_rvalid got %b exp 0", rva[0]); end
    @(posedge clk);
    #1;
    n_checks += 2;
    if (rda[0] !== 32'h0) begin n_fail++; $display("FAIL async_after_edge got %h exp 00000000", rda[0]); end
    if (rva[0] !== 1'b0) begin n_fail++; $display("FAIL async_after_edge_rv got %b exp 0", rva[0]); end
    we = 1'b0; wstrb = '0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 49) != 0);
      we      = ($urandom_range(0, 3) != 0);
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      wstrb   = 4'($urandom_range(0, 15));
      raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 3; k++) begin
        n_checks += 4;
        if (rda[k] !== exp_rd(k, raddr_a)) begin n_fail++; $display("FAIL rand_rdata_a inst%0d addr %0d got %h exp %h", k, raddr_a, rda[k], exp_rd(k, raddr_a)); end
        if (rdb[k] !== exp_rd(k, raddr_b)) begin n_fail++; $display("FAIL rand_rdata_b inst%0d addr %0d got %h exp %h", k, raddr_b, rdb[k], exp_rd(k, raddr_b)); end
        if (rva[k] !== exp_rv(k, raddr_a)) begin n_fail++; $display("FAIL rand_rvalid_a inst%0d addr %0d got %b exp %b", k, raddr_a, rva[k], exp_rv(k, raddr_a)); end
        if (rvb[k] !== exp_rv(k, raddr_b)) begin n_fail++; $display("FAIL rand_rvalid_b inst%0d addr %0d got %b exp %b", k, raddr_b, rvb[k], exp_rv(k, raddr_b)); end
      end
    end
    @(negedge clk);
    we = 1'b0; reset = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) for (int i = 0; i < 32; i++) begin
      mem[k][i] = '0;
      flg[k][i] = 1'b0;
    end
    test_reset;
    test_full_write;
    test_strobe;
    test_zero_range;
    test_bypass;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_bank.md
Name: reg_file_bank

Overview:
- Parametrised multi-port register bank for the single-cycle MIPS datapath.
- Generalises the single-bit D flip-flop to DEPTH words of WIDTH bits.
- Provides two asynchronous read ports and one clocked write port with byte strobes.
- Also provides optional write-to-read bypass, hardwired-zero register 0, and per-register "written" flags used by the debug/commit checker.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..256, need not be a power of two.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a read of the address being written this cycle returns the merged new data; 0 = returns stored data until the clock edge.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 clears bank)
- we  input  1  write enable
- waddr  input  ADDR_W  write address; ADDR_W = max(1, ceil(log2(DEPTH)))
- wdata  input  WIDTH  write data
- wstrb  input  WIDTH/8  byte-lane write strobes; bit i covers wdata[8i+7:8i]
- raddr_a  input  ADDR_W  read port A address
- rdata_a  output  WIDTH  read port A data (combinational)
- rvalid_a  output  1  1 = the addressed register has been written since reset
- raddr_b  input  ADDR_W  read port B address
- rdata_b  output  WIDTH  read port B data (combinational)
- rvalid_b  output  1  same as rvalid_a, for port B

Behaviour:

Reset
- Asynchronous: reset=0 immediately clears all words and written flags to 0, independent of clk and we.
- While reset=0: rdata_a = rdata_b = 0.
- While reset=0: rvalid_a/b = 0, except a ZERO_REG=1 read of address 0, which gives rvalid=1.
- Release takes effect at the next rising edge; there is no synchronous sequencing inside the block.

Write
- Occurs on a rising clk edge when reset=1 and we=1.
- For each lane i with wstrb[i]=1, word[waddr] lane i <= wdata lane i. Lanes with wstrb[i]=0 keep their value.
- flag[waddr] <= 1 if any wstrb bit is set. we=1 with wstrb=0 is a no-op and leaves the flag unchanged.

Ignored writes
- waddr >= DEPTH: write ignored.
- ZERO_REG=1 and waddr=0: write ignored.

Read
- Purely combinational, with zero latency from address to data.
- raddr >= DEPTH: rdata = 0, rvalid = 0.
- ZERO_REG=1 and raddr=0: rdata = 0, rvalid = 1, always.
- Both ports may address the same register. Each port is independent and identical.

Bypass (BYPASS=1)
- Applies when we=1, reset=1, the write is not ignored, and raddr==waddr.
- rdata = per-lane merge: wdata where wstrb=1, stored word elsewhere.
- rvalid = 1 if any strobe is set.
- With BYPASS=0, the read returns the stored word; the new value appears after the edge.

Other rules
- Simultaneous events: a read and a write of the same address in one cycle follow the bypass rules above. There is only one write port, so no write-write conflict exists.
- Reset mid-operation: an assertion coincident with a clk edge and we=1 takes priority; the write is dropped.
- No X propagation: all outputs are defined for every address value.

Decomposition:
- Shared package reg_file_pkg holds:
  - default WIDTH and DEPTH;
  - function addr_width(depth);
  - localparam ZERO_ADDR = 0;
  - function lane_merge(old, new, strb), used by both the storage and the bypass path.
- One sub-module, reg_file_word: a WIDTH-bit register with byte-strobe enables, a written flag and asynchronous active-low reset. It is instantiated DEPTH times via generate, with index 0 omitted when ZERO_REG=1.

Test Plan:
- Reset: hold reset=0 for 100 ns, read addresses 5 and 31. Required: rdata=0x00000000, rvalid=0; raddr 0 gives rvalid=1.
- Full write: reset=1, we=1, waddr=7, wdata=0xDEADBEEF, wstrb=4'b1111, one edge; then read A=7, B=7. Required: both rdata=0xDEADBEEF, rvalid=1.
- Byte strobe: on top of the previous write, write addr 7, wdata=0x11223344, wstrb=4'b0101. Required: rdata=0xDE22BE44.
- Zero register and range: write addr 0 with 0xFFFFFFFF; read addr 0. Required: rdata=0, rvalid=1. With DEPTH=20, a write to addr 25 is ignored and a read of 25 returns 0/rvalid=0.
- Bypass: BYPASS=1, word[3]=0xAAAAAAAA. Before the edge, set we=1, waddr=3, wdata=0x12345678, wstrb=4'b0011, raddr_a=3. Required: rdata_a=0xAAAA5678 immediately. Rerun with BYPASS=0: 0xAAAAAAAA before the edge, 0xAAAA5678 after.
- Async reset mid-operation: write 0x55 to addr 9, then drop reset at 3 ns before a clk edge with we=1 and waddr=9. Required: rdata for addr 9 = 0 immediately, flag = 0, and 0 after the edge.
